pam5_channel_model: RTL and testbench

//  Synthesizable 4-lane baseband channel emulator that sits directly downstream of the PCS Encoder.
//  - Consumes the 4D-PAM5 symbols on io_A..io_D (signed 3b, -2..+2).
//  - Applies per-lane programmable ISI (main cursor + post-cursor FIR), optional pseudo-noise and saturation.
//  - Emits signed receiver samples that drive the PDFD decoder under test.

---
 rtl/pam5_channel_pkg.sv | 38 +++
 rtl/pam5_channel_model_lane.sv | 110 +++++++++++
 rtl/pam5_channel_model.sv | 92 +++++++++
 tb/tb_pam5_channel_model.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pam5_channel_pkg.sv
// Shared types, constants and helpers for the 4-lane PAM5 channel emulator.
// Provides symbol/tap/sample typedefs, LFSR constants, saturation and LFSR step.
package pam5_channel_pkg;

    localparam int NUM_POST_DEF = 14;
    localparam int TAP_W_DEF    = 8;
    localparam int SAMPLE_W_DEF = 8;

    typedef logic signed [2:0]              symbol_t;
    typedef logic signed [TAP_W_DEF-1:0]    tap_t;
    typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Clamp v into the signed range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi)
            sat = hi;
        else if (v < lo)
            sat = lo;
        else
            sat = v;
    endfunction

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/pam5_channel_model_lane.sv
// channel_lane_fir: one lane of the channel - delay line, tap registers, MAC,
// optional LFSR noise (CHANNEL_NOISE_EN) and output saturation.
// Ports: clk_i/rst_i, in_valid_i/sym_i (symbol in), wr_en_i/wr_idx_i/wr_data_i
// (tap write, pre-decoded), noise_shift_i, out_en_i (stage-3 valid),
// sample_o (registered sample), sat_o (clamp happening this cycle).
module channel_lane_fir
    import pam5_channel_pkg::*;
#(
    parameter int NUM_POST  = 14,
    parameter int TAP_W     = 8,
    parameter int SAMPLE_W  = 8,
    parameter int OUT_SHIFT = 0,
    parameter int MAIN_RST  = 32,
    parameter int LANE      = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    input  symbol_t             sym_i,
    input  logic                wr_en_i,
    input  logic [3:0]          wr_idx_i,
    input  logic [TAP_W-1:0]    wr_data_i,
    input  logic [2:0]          noise_shift_i,
    input  logic                out_en_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sat_o
);

    localparam int ACC_W = TAP_W + 3 + $clog2(NUM_POST + 1);

    logic signed [TAP_W-1:0] tap_q [NUM_POST+1];
    symbol_t                 hist_q [NUM_POST];
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [SAMPLE_W-1:0]     sample_q;
    logic signed [SAMPLE_W-1:0] noise;
    logic signed [31:0]      y_d;
    logic signed [31:0]      ysat_d;

    // The incoming symbol is multiplied directly by the main cursor so the
    // accumulator registers in the same cycle the symbol enters the line.
    always_comb begin
        acc_d = ACC_W'(tap_q[0]) * ACC_W'(sym_i);
        for (int k = 1; k <= NUM_POST; k++) begin
            acc_d = acc_d + ACC_W'(tap_q[k]) * ACC_W'(hist_q[k-1]);
        end
    end

`ifdef CHANNEL_NOISE_EN
    localparam logic [15:0] SEED = LFSR_SEED ^ (16'(LANE) << 8);

    logic [15:0]                lfsr_q;
    logic signed [SAMPLE_W-1:0] nz_q;

    // Noise is captured alongside the accumulator, before the LFSR advances.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
            nz_q   <= '0;
        end else if (in_valid_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
            nz_q   <= lfsr_q[SAMPLE_W-1:0];
        end
    end

    assign noise = nz_q >>> noise_shift_i;
`else
    logic unused_noise_shift;
    assign unused_noise_shift = ^noise_shift_i;
    assign noise = '0;
`endif

    always_comb begin
        y_d    = 32'(acc_q >>> OUT_SHIFT) + 32'(noise);
        ysat_d = sat(y_d, SAMPLE_W);
        sat_o  = out_en_i && (ysat_d != y_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_POST; k++) begin
                hist_q[k] <= '0;
            end
            tap_q[0] <= TAP_W'(MAIN_RST);
            for (int k = 1; k <= NUM_POST; k++) begin
                tap_q[k] <= '0;
            end
            acc_q    <= '0;
            sample_q <= '0;
        end else begin
            if (in_valid_i) begin
                hist_q[0] <= sym_i;
                for (int k = 1; k < NUM_POST; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
                acc_q <= acc_d;
            end
            // Written after the MAC read, so a coincident symbol sees the old tap.
            if (wr_en_i) begin
                tap_q[wr_idx_i] <= wr_data_i;
            end
            if (out_en_i) begin
                sample_q <= ysat_d[SAMPLE_W-1:0];
            end
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/pam5_channel_model.sv
// Top of the 4-lane 4D-PAM5 channel emulator: tap-write decode, valid pipeline,
// sticky saturation flag, four channel_lane_fir instances. Noise: CHANNEL_NOISE_EN.
// Ports: clock/reset, io_in_valid + io_A..io_D symbols, io_tap_wr_* coefficient
// port, io_noise_shift, io_sat_clear; io_out_valid, io_out[3:0], io_sat_flag.
module pam5_channel_model
    import pam5_channel_pkg::*;
#(
    parameter int NUM_POST  = NUM_POST_DEF,
    parameter int TAP_W     = TAP_W_DEF,
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int OUT_SHIFT = 0,
    parameter int MAIN_RST  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_in_valid,
    input  logic [2:0]               io_A,
    input  logic [2:0]               io_B,
    input  logic [2:0]               io_C,
    input  logic [2:0]               io_D,
    input  logic                     io_tap_wr_en,
    input  logic [1:0]               io_tap_wr_lane,
    input  logic [3:0]               io_tap_wr_idx,
    input  logic [TAP_W-1:0]         io_tap_wr_data,
    input  logic [2:0]               io_noise_shift,
    input  logic                     io_sat_clear,
    output logic                     io_out_valid,
    output logic [3:0][SAMPLE_W-1:0] io_out,
    output logic                     io_sat_flag
);

    symbol_t    sym [4];
    logic       idx_ok;
    logic [3:0] wr_en;
    logic [3:0] lane_sat;
    logic       v1_q;
    logic       out_valid_q;
    logic       flag_q;
    logic       flag_d;

    assign sym[0] = io_A;
    assign sym[1] = io_B;
    assign sym[2] = io_C;
    assign sym[3] = io_D;

    assign idx_ok = (io_tap_wr_idx <= 4'(NUM_POST));

    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign wr_en[l] = io_tap_wr_en && idx_ok &&
                          (io_tap_wr_lane == 2'(l));

        channel_lane_fir #(
            .NUM_POST (NUM_POST),
            .TAP_W    (TAP_W),
            .SAMPLE_W (SAMPLE_W),
            .OUT_SHIFT(OUT_SHIFT),
            .MAIN_RST (MAIN_RST),
            .LANE     (l)
        ) u_lane (
            .clk_i        (clock),
            .rst_i        (reset),
            .in_valid_i   (io_in_valid),
            .sym_i        (sym[l]),
            .wr_en_i      (wr_en[l]),
            .wr_idx_i     (io_tap_wr_idx),
            .wr_data_i    (io_tap_wr_data),
            .noise_shift_i(io_noise_shift),
            .out_en_i     (v1_q),
            .sample_o     (io_out[l]),
            .sat_o        (lane_sat[l])
        );
    end

    // A clamp in the same cycle as a clear wins, keeping the flag set.
    assign flag_d = (flag_q && !io_sat_clear) || (|lane_sat);

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            v1_q        <= io_in_valid;
            out_valid_q <= v1_q;
            flag_q      <= flag_d;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_sat_flag  = flag_q;

endmodule

// File: tb/tb_pam5_channel_model.sv
// Self-checking bench for pam5_channel_model: directed vectors plus a
// behavioural channel model compared against the outputs every cycle.
module tb_pam5_channel_model;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            io_in_valid = 1'b0;
    logic [2:0]      io_A = '0, io_B = '0, io_C = '0, io_D = '0;
    logic            io_tap_wr_en = 1'b0;
    logic [1:0]      io_tap_wr_lane = '0;
    logic [3:0]      io_tap_wr_idx = '0;
    logic [7:0]      io_tap_wr_data = '0;
    logic [2:0]      io_noise_shift = '0;
    logic            io_sat_clear = 1'b0;
    logic            io_out_valid;
    logic [3:0][7:0] io_out;
    logic            io_sat_flag;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    pam5_channel_model dut (
        .clock         (clk),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_A          (io_A),
        .io_B          (io_B),
        .io_C          (io_C),
        .io_D          (io_D),
        .io_tap_wr_en  (io_tap_wr_en),
        .io_tap_wr_lane(io_tap_wr_lane),
        .io_tap_wr_idx (io_tap_wr_idx),
        .io_tap_wr_data(io_tap_wr_data),
        .io_noise_shift(io_noise_shift),
        .io_sat_clear  (io_sat_clear),
        .io_out_valid  (io_out_valid),
        .io_out        (io_out),
        .io_sat_flag   (io_sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int outs(input int l);
        logic signed [7:0] v;
        v = io_out[l];
        return int'(v);
    endfunction

    // ---------------- behavioural model ----------------
    int          tap_m [4][15];
    int          hist_m [4][15];
    logic [15:0] lfsr_m [4];
    bit          m1_v;
    int          m1_acc [4];
    int          m1_nz [4];
    bit          exp_v;
    int          exp_o [4];
    bit          exp_f;

    function automatic int sym_of(input int l);
        logic signed [2:0] s;
        case (l)
            0: s = io_A;
            1: s = io_B;
            2: s = io_C;
            default: s = io_D;
        endcase
        return int'(s);
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            for (int l = 0; l < 4; l++) begin
                for (int k = 0; k < 15; k++) begin
                    tap_m[l][k] = (k == 0) ? 32 : 0;
                    hist_m[l][k] = 0;
                end
                lfsr_m[l] = 16'hACE1 ^ (16'(l) << 8);
                exp_o[l] = 0;
            end
            m1_v = 0;
            exp_v = 0;
            exp_f = 0;
        end else begin
            bit any;
            int y;
            int c;
            int acc;
            logic signed [7:0] nb;
            any = 0;
            if (m1_v) begin
                for (int l = 0; l < 4; l++) begin
                    y = m1_acc[l] + (m1_nz[l] >>> io_noise_shift);
                    c = (y > 127) ? 127 : ((y < -128) ? -128 : y);
                    if (c != y) any = 1;
                    exp_o[l] = c;
                end
            end
            exp_f = (exp_f && !io_sat_clear) || any;
            exp_v = m1_v;
            m1_v = io_in_valid;
            if (io_in_valid) begin
                for (int l = 0; l < 4; l++) begin
                    for (int k = 14; k > 0; k--) hist_m[l][k] = hist_m[l][k-1];
                    hist_m[l][0] = sym_of(l);
                    acc = 0;
                    for (int k = 0; k < 15; k++) acc += tap_m[l][k] * hist_m[l][k];
                    m1_acc[l] = acc;
`ifdef CHANNEL_NOISE_EN
                    nb = lfsr_m[l][7:0];
                    m1_nz[l] = int'(nb);
                    lfsr_m[l] = galois(lfsr_m[l]);
`else
                    nb = '0;
                    m1_nz[l] = int'(nb);
`endif
                end
            end
            if (io_tap_wr_en && io_tap_wr_idx <= 4'd14) begin
                nb = io_tap_wr_data;
                tap_m[io_tap_wr_lane][io_tap_wr_idx] = int'(nb);
            end
        end
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cmp_valid", int'(io_out_valid), int'(exp_v));
            for (int l = 0; l < 4; l++) chk($sformatf("cmp_out%0d", l), outs(l), exp_o[l]);
            chk("cmp_flag", int'(io_sat_flag), int'(exp_f));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input bit v, input int a, input int b, input int c, input int d);
        io_in_valid = v;
        io_A = 3'(a);
        io_B = 3'(b);
        io_C = 3'(c);
        io_D = 3'(d);
        tick();
        io_in_valid = 1'b0;
    endtask

    task automatic wr(input int lane, input int idx, input int data);
        io_tap_wr_en = 1'b1;
        io_tap_wr_lane = 2'(lane);
        io_tap_wr_idx = 4'(idx);
        io_tap_wr_data = 8'(data);
        tick();
        io_tap_wr_en = 1'b0;
    endtask

    initial begin
        int ab;
        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;

        // 1: reset state and main cursor only
        chk("rst_valid", int'(io_out_valid), 0);
        chk("rst_out0", outs(0), 0);
        chk("rst_flag", int'(io_sat_flag), 0);
        send(1, 2, -1, 0, -2);
        chk("t1_lat_valid", int'(io_out_valid), 0);
        tick();
        chk("t1_valid", int'(io_out_valid), 1);
        chk("t1_a", outs(0), 64);
        chk("t1_b", outs(1), -32);
        chk("t1_c", outs(2), 0);
        chk("t1_d", outs(3), -64);
        tick();
        chk("t1_valid_drop", int'(io_out_valid), 0);
        chk("t1_hold", outs(0), 64);

        // 2: post-cursor, back to back and with a bubble
        do_reset();
        wr(0, 1, 16);
        send(1, 2, 0, 0, 0);
        send(1, 2, 0, 0, 0);
        chk("t2_first", outs(0), 64);
        tick();
        chk("t2_second", outs(0), 96);
        do_reset();
        wr(0, 1, 16);
        send(1, 2, 0, 0, 0);
        tick();
        chk("t2b_first", outs(0), 64);
        send(1, 2, 0, 0, 0);
        chk("t2b_bubble_valid", int'(io_out_valid), 0);
        tick();
        chk("t2b_second", outs(0), 96);

        // 3: saturation, clear, clear coincident with clamp
        do_reset();
        for (int k = 0; k < 15; k++) wr(2, k, 127);
        wr(2, 15, 5);
        for (int i = 0; i < 20; i++) send(1, 0, 0, 2, 0);
        tick();
        chk("t3_clamp", outs(2), 127);
        chk("t3_flag", int'(io_sat_flag), 1);
        for (int i = 0; i < 16; i++) send(1, 0, 0, 0, 0);
        tick();
        tick();
        chk("t3_clean", outs(2), 0);
        io_sat_clear = 1'b1;
        tick();
        chk("t3_cleared", int'(io_sat_flag), 0);
        send(1, 0, 0, 2, 0);
        tick();
        io_sat_clear = 1'b0;
        chk("t3_clear_vs_sat", int'(io_sat_flag), 1);

        // 4: write coincident with a valid symbol
        do_reset();
        io_tap_wr_en = 1'b1;
        io_tap_wr_lane = 2'd1;
        io_tap_wr_idx = 4'd0;
        io_tap_wr_data = 8'd64;
        send(1, 0, 1, 0, 0);
        io_tap_wr_en = 1'b0;
        send(1, 0, 1, 0, 0);
        chk("t4_old_tap", outs(1), 32);
        tick();
        chk("t4_new_tap", outs(1), 64);

        // 5: reset while a sample is in flight
        do_reset();
        wr(0, 0, 100);
        send(1, 2, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", int'(io_out_valid), 0);
        chk("t5_out", outs(0), 0);
        send(1, 1, 0, 0, 0);
        tick();
        chk("t5_tap_rst", outs(0), 32);

        // 6: noise
        do_reset();
        io_noise_shift = 3'd7;
        for (int i = 0; i < 20; i++) begin
            send(1, 0, 0, 0, 0);
            if (i > 0) begin
                for (int l = 0; l < 4; l++) begin
                    ab = outs(l) < 0 ? -outs(l) : outs(l);
                    chk("t6_small", int'(ab <= 1), 1);
                end
            end
        end
        do_reset();
        io_noise_shift = 3'd0;
        send(1, 0, 0, 0, 0);
        tick();
        for (int l = 0; l < 4; l++) begin
`ifdef CHANNEL_NOISE_EN
            chk("t6_first_noise", outs(l), -31);
`else
            chk("t6_no_noise", outs(l), 0);
`endif
        end
        for (int i = 0; i < 10; i++) send(1, 0, 0, 0, 0);

        // mixed stream against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            io_noise_shift = 3'($urandom_range(0, 7));
            io_sat_clear = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                io_tap_wr_en = 1'b1;
                io_tap_wr_lane = 2'($urandom_range(0, 3));
                io_tap_wr_idx = 4'($urandom_range(0, 15));
                io_tap_wr_data = 8'($urandom_range(0, 60) - 30);
            end
            send($urandom_range(0, 4) != 0,
                 $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2,
                 $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2);
            io_tap_wr_en = 1'b0;
        end
        io_sat_clear = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
